// File: rtl/mole_round_sequencer.sv
// mole_round_sequencer
// Runs each whack-a-mole round: an off-gap, a position pick, a lit window,
// then a hit/miss judgement. It keeps score, misses and rounds, and decides
// game over for the selected game mode.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   start        level: 1 = game enabled, 0 = abort / return to idle
//   mode         0 normal, 1 deathmatch, 2 timed, 3 normal
//   max_rounds   round limit for normal mode, sampled when leaving IDLE
//   time_between off-gap length minus 1 (cycles)
//   time_on      light-on window length minus 1 (cycles)
//   rand_pos     free-running random position
//   time_up      countdown expiry, used in timed mode only
//   key_valid    high while a key is held
//   key          code of the held key
//   lights       one-hot LED drive while light_on
//   light_on     high in ON
//   light_pos    current target position
//   hit / miss   one-cycle judgement pulses (registered, never together)
//   score        saturating hit count
//   misses       saturating miss count
//   game_over    high in OVER
//   busy         high in GAP or ON
//   dbg_state    current FSM state code
//
// Optional feature macro: WRONG_KEY_PENALTY_EN
//   defined   : a fresh press of a wrong valid key in ON ends the round as a miss
//   undefined : wrong keys are ignored
//
// Key handshake: key_valid is a level; only its rising edge (press) is acted
// on, so a held key, or a key code changing while held, never scores again.

module mole_round_sequencer #(
  parameter int CNT_W   = 28,
  parameter int POS_W   = 4,
  parameter int NUM_POS = 9,
  parameter int SCORE_W = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SCORE_W-1:0] max_rounds,
  input  logic [CNT_W-1:0]   time_between,
  input  logic [CNT_W-1:0]   time_on,
  input  logic [POS_W-1:0]   rand_pos,
  input  logic               time_up,
  input  logic               key_valid,
  input  logic [POS_W-1:0]   key,
  output logic [NUM_POS-1:0] lights,
  output logic               light_on,
  output logic [POS_W-1:0]   light_pos,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic               game_over,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GAP  = 3'd1;
  localparam logic [2:0] S_ON   = 3'd2;
  localparam logic [2:0] S_END  = 3'd3;  // registered round-end decision
  localparam logic [2:0] S_OVER = 3'd4;

  localparam logic [POS_W-1:0]   NP   = POS_W'(NUM_POS);
  localparam logic [POS_W-1:0]   LAST = POS_W'(NUM_POS - 1);
  localparam logic [SCORE_W-1:0] SAT  = '1;

  logic [2:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [POS_W-1:0]   r_pos;      // also serves as the previous position
  logic               r_kv_q;
  logic               r_hit;
  logic               r_miss;
  logic               r_was_miss;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_misses;
  logic [SCORE_W-1:0] r_rounds;
  logic [SCORE_W-1:0] r_max;

  logic [POS_W-1:0]   w_p1;
  logic [POS_W-1:0]   w_p2;
  logic [POS_W-1:0]   w_pick;
  logic               w_press;
  logic               w_cnt_zero;
  logic               w_wrong;
  logic               w_hit;
  logic               w_miss;
  logic               w_round_mode;
  logic               w_death_mode;
  logic               w_timed_stop;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == SAT) ? v : v + SCORE_W'(1);
  endfunction

  // Fold an out-of-range random value back into range, then avoid repeating
  // the last lit position.
  always_comb begin
    w_p1   = (rand_pos >= NP) ? (rand_pos - NP) : rand_pos;
    w_p2   = (w_p1 >= NP) ? '0 : w_p1;
    w_pick = w_p2;
    if (w_p2 == r_pos) begin
      w_pick = (w_p2 == LAST) ? '0 : (w_p2 + POS_W'(1));
    end
  end

  assign w_press      = key_valid & ~r_kv_q;
  assign w_cnt_zero   = (r_cnt == '0);
  assign w_round_mode = (mode == 2'd0) || (mode == 2'd3);
  assign w_death_mode = (mode == 2'd1);
  assign w_timed_stop = (mode == 2'd2) && time_up;

`ifdef WRONG_KEY_PENALTY_EN
  assign w_wrong = w_press && (key != r_pos) && (key < NP);
`else
  assign w_wrong = 1'b0;
`endif

  // Judgement is suppressed on abort; a correct press beats a timeout.
  assign w_hit  = (r_state == S_ON) && start && w_press && (key == r_pos);
  assign w_miss = (r_state == S_ON) && start && !w_hit && (w_cnt_zero || w_wrong);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pos      <= '0;
      r_kv_q     <= 1'b0;
      r_hit      <= 1'b0;
      r_miss     <= 1'b0;
      r_was_miss <= 1'b0;
      r_score    <= '0;
      r_misses   <= '0;
      r_rounds   <= '0;
      r_max      <= '0;
    end else begin
      r_kv_q <= key_valid;
      r_hit  <= w_hit;
      r_miss <= w_miss;

      if (w_hit) begin
        r_score  <= sat_inc(r_score);
        r_rounds <= sat_inc(r_rounds);
      end else if (w_miss) begin
        r_misses <= sat_inc(r_misses);
        r_rounds <= sat_inc(r_rounds);
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_score  <= '0;
            r_misses <= '0;
            r_rounds <= '0;
            r_max    <= (max_rounds == '0) ? SCORE_W'(1) : max_rounds;
            r_cnt    <= time_between;
            r_state  <= S_GAP;
          end
        end
        S_GAP: begin
          if (!start) begin
            r_state <= S_IDLE;
          end else if (w_timed_stop) begin
            r_state <= S_OVER;
          end else if (w_cnt_zero) begin
            r_pos   <= w_pick;
            r_cnt   <= time_on;
            r_state <= S_ON;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_ON: begin
          if (!start) begin
            r_state <= S_IDLE;
          end else if (w_timed_stop) begin
            r_state <= S_OVER;
          end else if (w_hit || w_miss) begin
            r_was_miss <= w_miss;
            r_state    <= S_END;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_END: begin
          if (!start) begin
            r_state <= S_IDLE;
          end else if (w_timed_stop) begin
            r_state <= S_OVER;
          end else if (w_round_mode && (r_rounds == r_max)) begin
            r_state <= S_OVER;
          end else if (w_death_mode && r_was_miss) begin
            r_state <= S_OVER;
          end else begin
            r_cnt   <= time_between;
            r_state <= S_GAP;
          end
        end
        S_OVER: begin
          if (!start) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign light_on  = (r_state == S_ON);
  assign lights    = light_on ? (NUM_POS'(1) << r_pos) : '0;
  assign light_pos = r_pos;
  assign hit       = r_hit;
  assign miss      = r_miss;
  assign score     = r_score;
  assign misses    = r_misses;
  assign game_over = (r_state == S_OVER);
  assign busy      = (r_state == S_GAP) || (r_state == S_ON);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mole_round_sequencer.sv
module tb_mole_round_sequencer;

  localparam int CNT_W   = 28;
  localparam int POS_W   = 4;
  localparam int NUM_POS = 9;
  localparam int SCORE_W = 7;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [1:0]         mode;
  logic [SCORE_W-1:0] max_rounds;
  logic [CNT_W-1:0]   time_between;
  logic [CNT_W-1:0]   time_on;
  logic [POS_W-1:0]   rand_pos;
  logic               time_up;
  logic               key_valid;
  logic [POS_W-1:0]   key;
  logic [NUM_POS-1:0] lights;
  logic               light_on;
  logic [POS_W-1:0]   light_pos;
  logic               hit;
  logic               miss;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] misses;
  logic               game_over;
  logic               busy;
  logic [2:0]         dbg_state;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_got;
  logic [15:0] mon_exp;
  int exp_misses;

  // clock / reset block
  always #5 clk = ~clk;

  mole_round_sequencer #(
    .CNT_W(CNT_W), .POS_W(POS_W), .NUM_POS(NUM_POS), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .max_rounds(max_rounds), .time_between(time_between), .time_on(time_on),
    .rand_pos(rand_pos), .time_up(time_up), .key_valid(key_valid), .key(key),
    .lights(lights), .light_on(light_on), .light_pos(light_pos),
    .hit(hit), .miss(miss), .score(score), .misses(misses),
    .game_over(game_over), .busy(busy), .dbg_state(dbg_state)
  );

  function automatic logic [15:0] ev(input logic h, input logic m,
                                     input logic [6:0] s, input logic [6:0] mi);
    return {h, m, s, mi};
  endfunction

  // scoreboard: every hit/miss pulse is matched against the expected queue
  always @(negedge clk) begin
    if (!reset && (hit || miss)) begin
      mon_got = {hit, miss, score, misses};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $error("FAIL unexpected_pulse obs=%h exp=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        assert (mon_got === mon_exp) else begin
          bad++;
          $error("FAIL pulse_event obs=%h exp=%h", mon_got, mon_exp);
        end
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_light(input logic v, input int budget);
    int n = 0;
    while (light_on !== v && n < budget) begin
      step(1);
      n++;
    end
    chk("wait_light", {31'd0, light_on}, {31'd0, v});
  endtask

  task automatic wait_over(input int budget);
    int n = 0;
    while (game_over !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    chk("wait_over", {31'd0, game_over}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'd0; max_rounds = '0;
    time_between = '0; time_on = '0; rand_pos = '0; time_up = 1'b0;
    key_valid = 1'b0; key = '0;
    step(2);
    chk("rst_light_on", light_on, 0);
    chk("rst_lights", lights, 0);
    chk("rst_busy", busy, 0);
    chk("rst_over", game_over, 0);
    reset = 1'b0;
    step(1);
    chk("idle_busy", busy, 0);
    chk("idle_score", score, 0);

    // 1: normal mode, no keys, phase lengths and two misses
    mode = 2'd0; max_rounds = 7'd2; time_between = 28'd3; time_on = 28'd5; rand_pos = 4'd4;
    exp_q.push_back(ev(1'b0, 1'b1, 7'd0, 7'd1));
    exp_q.push_back(ev(1'b0, 1'b1, 7'd0, 7'd2));
    start = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_gap_busy", busy, 1);
      chk("t1_gap_dark", light_on, 0);
      step(1);
    end
    for (int i = 0; i < 6; i++) begin
      chk("t1_on", light_on, 1);
      chk("t1_lights", lights, 32'h010);
      step(1);
    end
    chk("t1_miss", miss, 1);
    chk("t1_misses", misses, 1);
    chk("t1_off", light_on, 0);
    wait_light(1'b1, 20);
    chk("t1_pos_r2", light_pos, 5);
    wait_over(30);
    chk("t1_misses_end", misses, 2);
    chk("t1_score_end", score, 0);
    start = 1'b0;
    step(1);
    chk("t1_idle", game_over, 0);
    chk("t1_misses_held", misses, 2);

    // 2: correct press on 3rd ON cycle, then a held key never scores again
    mode = 2'd0; max_rounds = 7'd2; time_between = 28'd1; time_on = 28'd9; rand_pos = 4'd4;
    exp_q.push_back(ev(1'b1, 1'b0, 7'd1, 7'd0));
    start = 1'b1;
    wait_light(1'b1, 20);
    chk("t2_pos", light_pos, 4);
    step(2);
    key = 4'd4; key_valid = 1'b1;
    step(1);
    chk("t2_hit", hit, 1);
    chk("t2_score", score, 1);
    chk("t2_light_off", light_on, 0);
    rand_pos = 4'd6;
    key = 4'd6;
    exp_q.push_back(ev(1'b0, 1'b1, 7'd1, 7'd1));
    wait_over(60);
    chk("t2_score_end", score, 1);
    chk("t2_misses_end", misses, 1);
    key_valid = 1'b0; start = 1'b0;
    step(1);

    // 3: deathmatch, hit then timeout ends the game (round limit ignored)
    mode = 2'd1; max_rounds = 7'd1; time_between = 28'd2; time_on = 28'd4; rand_pos = 4'd2;
    exp_q.push_back(ev(1'b1, 1'b0, 7'd1, 7'd0));
    exp_q.push_back(ev(1'b0, 1'b1, 7'd1, 7'd1));
    start = 1'b1;
    wait_light(1'b1, 20);
    key = 4'd2; key_valid = 1'b1;
    step(1);
    chk("t3_hit", hit, 1);
    key_valid = 1'b0;
    step(1);
    chk("t3_continue", busy, 1);
    chk("t3_not_over", game_over, 0);
    wait_light(1'b1, 20);
    step(5);
    chk("t3_miss", miss, 1);
    step(1);
    chk("t3_over", game_over, 1);
    chk("t3_score", score, 1);
    chk("t3_misses", misses, 1);
    start = 1'b0;
    step(1);

    // 4: position folding and no-repeat rule
    mode = 2'd0; max_rounds = 7'd5; time_between = 28'd0; time_on = 28'd2; rand_pos = 4'd13;
    for (int i = 1; i <= 5; i++) exp_q.push_back(ev(1'b0, 1'b1, 7'd0, 7'(i)));
    start = 1'b1;
    wait_light(1'b1, 20);
    chk("t4_pos13", light_pos, 4);
    chk("t4_lights13", lights, 32'h010);
    rand_pos = 4'd4;
    wait_light(1'b0, 20); wait_light(1'b1, 20);
    chk("t4_pos_repeat", light_pos, 5);
    rand_pos = 4'd15;
    wait_light(1'b0, 20); wait_light(1'b1, 20);
    chk("t4_pos15", light_pos, 6);
    rand_pos = 4'd8;
    wait_light(1'b0, 20); wait_light(1'b1, 20);
    chk("t4_pos8", light_pos, 8);
    wait_light(1'b0, 20); wait_light(1'b1, 20);
    chk("t4_pos_wrap", light_pos, 0);
    chk("t4_lights_wrap", lights, 32'h001);
    wait_over(20);
    chk("t4_misses", misses, 5);
    start = 1'b0;
    step(1);

    // 5: timed mode, time_up together with a correct press
    mode = 2'd2; max_rounds = 7'd1; time_between = 28'd1; time_on = 28'd20; rand_pos = 4'd1;
    exp_q.push_back(ev(1'b1, 1'b0, 7'd1, 7'd0));
    start = 1'b1;
    wait_light(1'b1, 20);
    step(3);
    key = 4'd1; key_valid = 1'b1; time_up = 1'b1;
    step(1);
    chk("t5_over", game_over, 1);
    chk("t5_score", score, 1);
    chk("t5_light_off", light_on, 0);
    time_up = 1'b0; key_valid = 1'b0; start = 1'b0;
    step(1);
    chk("t5_idle", game_over, 0);
    chk("t5_score_held", score, 1);
    // time_up during the gap stops the game with no judgement
    time_between = 28'd10;
    start = 1'b1;
    step(3);
    time_up = 1'b1;
    step(1);
    chk("t5_gap_over", game_over, 1);
    chk("t5_gap_score", score, 0);
    time_up = 1'b0; start = 1'b0;
    step(1);

    // 6: wrong key, abort, then asynchronous reset mid-ON
    mode = 2'd0; max_rounds = 7'd5; time_between = 28'd2; time_on = 28'd10; rand_pos = 4'd7;
    start = 1'b1;
    wait_light(1'b1, 20);
    chk("t6_pos", light_pos, 7);
    step(1);
`ifdef WRONG_KEY_PENALTY_EN
    exp_q.push_back(ev(1'b0, 1'b1, 7'd0, 7'd1));
    exp_misses = 1;
`else
    exp_misses = 0;
`endif
    key = 4'd2; key_valid = 1'b1;
    step(1);
`ifdef WRONG_KEY_PENALTY_EN
    chk("t6_pen_miss", miss, 1);
    chk("t6_pen_off", light_on, 0);
`else
    chk("t6_ignored_on", light_on, 1);
    chk("t6_ignored_miss", miss, 0);
`endif
    chk("t6_misses", misses, 32'(exp_misses));
    key_valid = 1'b0; start = 1'b0;
    step(1);
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_light", light_on, 0);
    chk("t6_abort_held", misses, 32'(exp_misses));
    start = 1'b1;
    wait_light(1'b1, 20);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_light", light_on, 0);
    chk("t6_rst_lights", lights, 0);
    chk("t6_rst_pos", light_pos, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_state", dbg_state, 0);
    chk("t6_rst_misses", misses, 0);
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0;
    step(2);
    chk("t6_post_idle", busy, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
